// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
// Package  : servo_pkg
// Purpose  : Shared widths, position-word layout and state encodings for the
//            servo PWM capture block.
// Revision : 1.0 - initial release
// ============================================================================
package servo_pkg;

    localparam int CHAN_BITS  = 4;
    localparam int WIDTH_BITS = 12;
    localparam logic [WIDTH_BITS-1:0] WIDTH_MAX = 12'd4095;

    // Position word is {channel, width_us}
    localparam int POS_WIDTH_LSB = 0;
    localparam int POS_CHAN_LSB  = WIDTH_BITS;

    typedef enum logic [0:0] {
        OUT_IDLE = 1'b0,
        OUT_SEND = 1'b1
    } out_state_t;

    typedef enum logic [1:0] {
        CH_ARM  = 2'd0,
        CH_IDLE = 2'd1,
        CH_HIGH = 2'd2
    } ch_state_t;

endpackage
`default_nettype wire

// File: rtl/servo_pulse_meter.sv
`default_nettype none
// ============================================================================
// Module   : servo_pulse_meter
// Purpose  : Per-channel pulse-width meter: synchronizer, edge detect, us
//            prescaler, saturating width counter and pending result.
//            SERVO_CAPTURE_TIMEOUT_EN adds a signal-loss (width 0) report.
// Revision : 1.0 - initial release
// ============================================================================
module servo_pulse_meter
    import servo_pkg::*;
#(
    parameter int CLOCKS_PER_US = 50,
    parameter int TIMEOUT_MS    = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pwm,
    input  logic                  i_clr,
    output logic                  o_pending,
    output logic [WIDTH_BITS-1:0] o_width
);

    localparam int c_pre_bits = (CLOCKS_PER_US > 1) ? $clog2(CLOCKS_PER_US) : 1;
    localparam logic [c_pre_bits-1:0] c_pre_last = c_pre_bits'(CLOCKS_PER_US - 1);

    logic [1:0]            r_sync;
    logic                  r_last;
    ch_state_t             r_state;
    logic [c_pre_bits-1:0] r_pre;
    logic [WIDTH_BITS-1:0] r_width;

    logic                  w_level;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_tick;
    logic                  w_timeout;
    logic [WIDTH_BITS-1:0] w_width_next;

    // Synchronizer is left unreset so it holds the true pin level at reset release
    always_ff @(posedge clk) begin
        r_sync <= {r_sync[0], i_pwm};
        r_last <= r_sync[1];
    end

    assign w_level = r_sync[1];
    assign w_rise  = w_level & ~r_last;
    assign w_fall  = ~w_level & r_last;
    assign w_tick  = (r_pre == c_pre_last);
    // Includes the falling-edge cycle so the result is exactly floor(cycles/CLOCKS_PER_US)
    assign w_width_next = (w_tick && (r_width != WIDTH_MAX)) ? r_width + 1'b1 : r_width;

`ifdef SERVO_CAPTURE_TIMEOUT_EN
    localparam int c_ms_bits = $clog2(TIMEOUT_MS + 1);
    localparam logic [c_ms_bits-1:0] c_ms_limit = c_ms_bits'(TIMEOUT_MS);

    logic [c_pre_bits-1:0] r_tmo_pre;
    logic [9:0]            r_tmo_us;
    logic [c_ms_bits-1:0]  r_tmo_ms;
    logic                  r_tmo_armed;

    assign w_timeout = r_tmo_armed && (r_tmo_ms == c_ms_limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_pre   <= '0;
            r_tmo_us    <= '0;
            r_tmo_ms    <= '0;
            r_tmo_armed <= 1'b0;
        end else if (w_rise || w_fall) begin
            r_tmo_pre   <= '0;
            r_tmo_us    <= '0;
            r_tmo_ms    <= '0;
            r_tmo_armed <= 1'b1;
        end else if (w_timeout) begin
            r_tmo_armed <= 1'b0;
        end else if (r_tmo_armed) begin
            if (r_tmo_pre == c_pre_last) begin
                r_tmo_pre <= '0;
                if (r_tmo_us == 10'd999) begin
                    r_tmo_us <= '0;
                    r_tmo_ms <= r_tmo_ms + 1'b1;
                end else begin
                    r_tmo_us <= r_tmo_us + 1'b1;
                end
            end else begin
                r_tmo_pre <= r_tmo_pre + 1'b1;
            end
        end
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_MS;
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CH_ARM;
            r_pre     <= '0;
            r_width   <= '0;
            o_width   <= '0;
            o_pending <= 1'b0;
        end else begin
            // A result latched in the same cycle as the clear takes priority
            if (i_clr) begin
                o_pending <= 1'b0;
            end
            if (w_timeout) begin
                o_width   <= '0;
                o_pending <= 1'b1;
            end
            case (r_state)
                CH_ARM: begin
                    if (!w_level) begin
                        r_state <= CH_IDLE;
                    end
                end
                CH_IDLE: begin
                    if (w_rise) begin
                        r_pre   <= '0;
                        r_width <= '0;
                        r_state <= CH_HIGH;
                    end
                end
                CH_HIGH: begin
                    r_pre   <= w_tick ? '0 : r_pre + 1'b1;
                    r_width <= w_width_next;
                    if (w_fall) begin
                        r_state <= CH_IDLE;
                        if (w_width_next != '0) begin
                            o_width   <= w_width_next;
                            o_pending <= 1'b1;
                        end
                    end
                end
                default: r_state <= CH_ARM;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/servo_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_capture
// Purpose  : Measures servo PWM pulse widths on CHANNELS pins and streams one
//            {channel, width_us} word per pulse over a stb/ack handshake.
//            Optional signal-loss words: define SERVO_CAPTURE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module servo_pwm_capture
    import servo_pkg::*;
#(
    parameter int CHANNELS      = 8,
    parameter int CLOCKS_PER_US = 50,
    parameter int TIMEOUT_MS    = 25
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] pwm_in,
    output logic [15:0]         output_position,
    output logic                output_position_stb,
    input  logic                output_position_ack
);

    // Arrays are sized to the full channel-field range so a CHAN_BITS index is exact
    localparam int c_slots = 1 << CHAN_BITS;
    localparam logic [CHAN_BITS:0]   c_chans = (CHAN_BITS + 1)'(CHANNELS);
    localparam logic [CHAN_BITS-1:0] c_last  = CHAN_BITS'(CHANNELS - 1);

    logic [c_slots-1:0]    w_pending;
    logic [c_slots-1:0]    w_clr;
    logic [WIDTH_BITS-1:0] w_result [c_slots];

    out_state_t            r_out_state;
    logic [CHAN_BITS-1:0]  r_ptr;

    logic                  w_found;
    logic [CHAN_BITS-1:0]  w_idx;
    logic [CHAN_BITS:0]    w_sum;
    logic [CHAN_BITS-1:0]  w_ptr_next;

    for (genvar g = 0; g < c_slots; g++) begin : g_slot
        if (g < CHANNELS) begin : g_chan
            servo_pulse_meter #(
                .CLOCKS_PER_US (CLOCKS_PER_US),
                .TIMEOUT_MS    (TIMEOUT_MS)
            ) u_meter (
                .clk       (clk),
                .rst       (rst),
                .i_pwm     (pwm_in[g]),
                .i_clr     (w_clr[g]),
                .o_pending (w_pending[g]),
                .o_width   (w_result[g])
            );
        end else begin : g_unused
            logic w_unused_clr;
            assign w_unused_clr = w_clr[g];
            assign w_pending[g] = 1'b0;
            assign w_result[g]  = '0;
        end
    end

    // Round-robin: first pending channel at or after the pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_sum   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_sum = {1'b0, r_ptr} + (CHAN_BITS + 1)'(i);
            if (w_sum >= c_chans) begin
                w_sum = w_sum - c_chans;
            end
            if (!w_found && w_pending[w_sum[CHAN_BITS-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_sum[CHAN_BITS-1:0];
            end
        end
    end

    assign w_ptr_next = (w_idx == c_last) ? '0 : w_idx + 1'b1;

    always_comb begin
        w_clr = '0;
        if (r_out_state == OUT_IDLE && w_found) begin
            w_clr[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_state         <= OUT_IDLE;
            r_ptr               <= '0;
            output_position     <= '0;
            output_position_stb <= 1'b0;
        end else begin
            case (r_out_state)
                OUT_IDLE: begin
                    if (w_found) begin
                        output_position[POS_CHAN_LSB +: CHAN_BITS]   <= w_idx;
                        output_position[POS_WIDTH_LSB +: WIDTH_BITS] <= w_result[w_idx];
                        output_position_stb <= 1'b1;
                        r_ptr               <= w_ptr_next;
                        r_out_state         <= OUT_SEND;
                    end
                end
                OUT_SEND: begin
                    if (output_position_ack) begin
                        output_position_stb <= 1'b0;
                        r_out_state         <= OUT_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_servo_pwm_capture
// Purpose  : Self-checking bench for servo_pwm_capture (table vectors, corner
//            sequences, randomized pulses against an arithmetic model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_capture;

    localparam int c_channels = 8;
    localparam int c_cpu      = 2;
    localparam int c_tmo_ms   = 6;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [c_channels-1:0] pwm_in = '0;
    logic [15:0]           output_position;
    logic                  output_position_stb;
    logic                  output_position_ack = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [15:0] got[$];
    logic [15:0] exp_q[$];
    int          lens[$];

    logic        mon_hold = 1'b0;
    logic        mon_last_hs = 1'b0;
    logic [15:0] mon_held = '0;
    int          mon_len = 0;

    typedef struct {
        int          ch;
        int          cycles;
        bit          has_word;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[7];

    servo_pwm_capture #(
        .CHANNELS      (c_channels),
        .CLOCKS_PER_US (c_cpu),
        .TIMEOUT_MS    (c_tmo_ms)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .pwm_in              (pwm_in),
        .output_position     (output_position),
        .output_position_stb (output_position_stb),
        .output_position_ack (output_position_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation still running at time limit, errors=%0d of %0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // Protocol monitor: words are captured on handshake, mid-edge sampled
    always @(negedge clk) begin
        if (rst) begin
            mon_hold    = 1'b0;
            mon_last_hs = 1'b0;
            mon_len     = 0;
        end else begin
            if (mon_last_hs) begin
                checks++;
                if (output_position_stb) begin
                    errors++;
                    $display("FAIL stb_gap: stb=%b right after handshake, required 0", output_position_stb);
                end
            end
            if (mon_hold) begin
                checks++;
                if (!output_position_stb || output_position !== mon_held) begin
                    errors++;
                    $display("FAIL hold: stb=%b pos=%h, required stb=1 pos=%h",
                             output_position_stb, output_position, mon_held);
                end
            end
            if (output_position_stb) mon_len++;
            if (output_position_stb && output_position_ack) begin
                got.push_back(output_position);
                lens.push_back(mon_len);
                mon_len     = 0;
                mon_hold    = 1'b0;
                mon_last_hs = 1'b1;
            end else begin
                mon_last_hs = 1'b0;
                mon_hold    = output_position_stb;
                mon_held    = output_position;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        got.delete();
        lens.delete();
        exp_q.delete();
        check16("reset_pos", output_position, 16'h0000);
        check16("reset_stb", {15'd0, output_position_stb}, 16'h0000);
    endtask

    task automatic pulse(input int ch, input int cycles);
        pwm_in[ch] = 1'b1;
        tick(cycles);
        pwm_in[ch] = 1'b0;
    endtask

    // Behavioural reference: width is whole microseconds of high time, saturated
    function automatic logic [15:0] model_word(input int ch, input int cycles);
        int          us;
        logic [3:0]  c4;
        logic [11:0] w12;
        us = cycles / c_cpu;
        if (us > 4095) us = 4095;
        c4  = ch[3:0];
        w12 = us[11:0];
        return {c4, w12};
    endfunction

    task automatic check_stream(input string name, input bit one_cycle_stb);
        int n;
        n = 0;
        while (got.size() < exp_q.size() && n < 400) begin
            tick(1);
            n++;
        end
        tick(30);
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d words, required %0d", name, got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_word%0d: got %h, required %h", name, i,
                         (i < got.size()) ? got[i] : 16'hxxxx, exp_q[i]);
            end
            if (one_cycle_stb && i < lens.size()) begin
                checks++;
                if (lens[i] != 1) begin
                    errors++;
                    $display("FAIL %s_stblen%0d: got %0d cycles, required 1", name, i, lens[i]);
                end
            end
        end
        got.delete();
        lens.delete();
        exp_q.delete();
    endtask

    initial begin
        int perm[c_channels];
        int dur[4];
        int nch;
        int t;
        int j;
        int tmp;

        vecs[0] = '{2, 3000, 1'b1, 16'h25DC};
        vecs[1] = '{0, 8200, 1'b1, 16'h0FFF};
        vecs[2] = '{1, 8190, 1'b1, 16'h1FFF};
        vecs[3] = '{6, 1,    1'b0, 16'h0000};
        vecs[4] = '{6, 2,    1'b1, 16'h6001};
        vecs[5] = '{7, 3,    1'b1, 16'h7001};
        vecs[6] = '{5, 5,    1'b1, 16'h5002};

        for (int i = 0; i < 7; i++) begin
            do_reset();
            pulse(vecs[i].ch, vecs[i].cycles);
            if (vecs[i].has_word) exp_q.push_back(vecs[i].exp);
            check_stream($sformatf("vec%0d", i), 1'b1);
        end

        // Simultaneous falling edges: round robin from pointer 0
        do_reset();
        pwm_in[1] = 1'b1;
        pwm_in[5] = 1'b1;
        tick(2000);
        pwm_in[1] = 1'b0;
        pwm_in[5] = 1'b0;
        exp_q.push_back(16'h13E8);
        exp_q.push_back(16'h53E8);
        check_stream("simul", 1'b1);

        // Back-pressure: latest result wins, intermediate one is dropped
        do_reset();
        output_position_ack = 1'b0;
        pulse(3, 2000);
        tick(10);
        check16("bp_first", output_position, 16'h33E8);
        check16("bp_stb", {15'd0, output_position_stb}, 16'h0001);
        pulse(3, 2400);
        tick(10);
        pulse(3, 2800);
        tick(10);
        check16("bp_held", output_position, 16'h33E8);
        output_position_ack = 1'b1;
        exp_q.push_back(16'h33E8);
        exp_q.push_back(16'h3578);
        check_stream("bp", 1'b0);

        // Pin high through reset release is ignored until it goes low
        pwm_in[4] = 1'b1;
        do_reset();
        tick(1600);
        pwm_in[4] = 1'b0;
        tick(50);
        pulse(4, 1800);
        exp_q.push_back(16'h4384);
        check_stream("arm", 1'b1);

        // Reset mid-pulse and mid-SEND drops everything in flight
        do_reset();
        output_position_ack = 1'b0;
        pwm_in[1] = 1'b1;
        pulse(0, 100);
        tick(10);
        check16("midsend_stb", {15'd0, output_position_stb}, 16'h0001);
        rst = 1'b1;
        tick(1);
        check16("midrst_pos", output_position, 16'h0000);
        check16("midrst_stb", {15'd0, output_position_stb}, 16'h0000);
        tick(2);
        rst = 1'b0;
        output_position_ack = 1'b1;
        tick(100);
        pwm_in[1] = 1'b0;
        check_stream("midrst", 1'b1);

        // Randomized overlapping pulses with distinct fall times
        for (int r = 0; r < 15; r++) begin
            do_reset();
            for (int i = 0; i < c_channels; i++) perm[i] = i;
            for (int i = c_channels - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = perm[i];
                perm[i] = perm[j];
                perm[j] = tmp;
            end
            nch = $urandom_range(1, 4);
            t = 0;
            for (int k = 0; k < nch; k++) begin
                t = t + 20 + $urandom_range(0, 300);
                dur[k] = t;
                pwm_in[perm[k]] = 1'b1;
            end
            t = 0;
            for (int k = 0; k < nch; k++) begin
                tick(dur[k] - t);
                t = dur[k];
                pwm_in[perm[k]] = 1'b0;
                exp_q.push_back(model_word(perm[k], dur[k]));
            end
            check_stream($sformatf("rand%0d", r), 1'b1);
        end

`ifdef SERVO_CAPTURE_TIMEOUT_EN
        do_reset();
        pulse(6, 100);
        exp_q.push_back(16'h6032);
        check_stream("tmo_pulse", 1'b1);
        tick(11700);
        checks++;
        if (got.size() != 0) begin
            errors++;
            $display("FAIL tmo_early: got %0d words, required 0", got.size());
        end
        exp_q.push_back(16'h6000);
        check_stream("tmo_loss", 1'b1);
        tick(13000);
        checks++;
        if (got.size() != 0) begin
            errors++;
            $display("FAIL tmo_repeat: got %0d words, required 0", got.size());
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
